// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning the architectural HI/LO pair.
// Shift-add multiply, restoring divide with a sign-fixup cycle; stalls HI/LO consumers while busy.
module ex_muldiv #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             special_ex,
  input  logic [5:0]       funct_ex,
  input  logic [WIDTH-1:0] rs_ex,
  input  logic [WIDTH-1:0] rt_ex,
  input  logic             cancel,
  output logic             busy,
  output logic             stall_ex,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;      // product high half / partial remainder
  logic [WIDTH-1:0] qr;       // multiplier bits / quotient bits
  logic [WIDTH-1:0] mcand;    // multiplicand / divisor magnitude
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH-1:0] dvd_raw;

  // Decode
  logic is_mfhi, is_mthi, is_mflo, is_mtlo, is_mul, is_div, hilo_op, start;
  logic signed_op, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign is_mfhi   = special_ex && (funct_ex == F_MFHI);
  assign is_mthi   = special_ex && (funct_ex == F_MTHI);
  assign is_mflo   = special_ex && (funct_ex == F_MFLO);
  assign is_mtlo   = special_ex && (funct_ex == F_MTLO);
  assign is_mul    = special_ex && ((funct_ex == F_MULT) || (funct_ex == F_MULTU));
  assign is_div    = special_ex && ((funct_ex == F_DIV) || (funct_ex == F_DIVU));
  assign hilo_op   = is_mfhi || is_mthi || is_mflo || is_mtlo || is_mul || is_div;
  assign start     = (state == S_IDLE) && (is_mul || is_div) && !cancel;

  assign signed_op = !funct_ex[0];
  assign rs_neg    = signed_op && rs_ex[WIDTH-1];
  assign rt_neg    = signed_op && rt_ex[WIDTH-1];
  assign rs_mag    = rs_neg ? (~rs_ex + 1'b1) : rs_ex;
  assign rt_mag    = rt_neg ? (~rt_ex + 1'b1) : rt_ex;

  assign stall_ex  = busy && hilo_op;
  assign mf_data   = is_mfhi ? hi_o : (is_mflo ? lo_o : '0);

  // Multiply datapath: one shift-add step, or a full product when FAST_MUL
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] fast_prod;
  logic [2*WIDTH-1:0] mul_mag;
  logic [2*WIDTH-1:0] mul_res;

  assign mul_sum   = {1'b0, acc} + (qr[0] ? {1'b0, mcand} : '0);
  assign mul_step  = {mul_sum, qr[WIDTH-1:1]};
  assign fast_prod = {{WIDTH{1'b0}}, mcand} * {{WIDTH{1'b0}}, qr};
  assign mul_mag   = FAST_MUL ? fast_prod : mul_step;
  assign mul_res   = neg_q ? (~mul_mag + 1'b1) : mul_mag;

  // Restoring divide step: the remainder always fits WIDTH bits after the compare
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign div_shift = {acc, qr[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand};
  assign div_ok    = !div_diff[WIDTH];
  assign q_fix     = neg_q ? (~qr + 1'b1) : qr;
  assign r_fix     = neg_r ? (~acc + 1'b1) : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      hi_o     <= '0;
      lo_o     <= '0;
      acc      <= '0;
      qr       <= '0;
      mcand    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      dvd_raw  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= is_mul ? S_MUL : S_DIV;
            busy     <= 1'b1;
            cnt      <= (is_mul && FAST_MUL) ? '0 : CW'(WIDTH - 1);
            acc      <= '0;
            qr       <= is_mul ? rt_mag : rs_mag;
            mcand    <= is_mul ? rs_mag : rt_mag;
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            div_zero <= (rt_ex == '0);
            dvd_raw  <= rs_ex;
          end else begin
            if (is_mthi) hi_o <= rs_ex;
            if (is_mtlo) lo_o <= rs_ex;
          end
        end
        S_MUL: begin
          if (cancel) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= mul_step[2*WIDTH-1:WIDTH];
            qr  <= mul_step[WIDTH-1:0];
            if (cnt == '0) begin
              {hi_o, lo_o} <= mul_res;
              state        <= S_IDLE;
              busy         <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        S_DIV: begin
          if (cancel) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            qr  <= {qr[WIDTH-2:0], div_ok};
            if (cnt == '0) state <= S_FIX;
            else           cnt   <= cnt - CW'(1);
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            // Divide by zero leaves the dividend in HI and all ones in LO
            lo_o <= div_zero ? '1 : q_fix;
            hi_o <= div_zero ? dvd_raw : r_fix;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed cases with literal results, then randomized traffic
// checked every cycle against an arithmetic model of HI/LO and busy latency.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        special_ex;
  logic [5:0]  funct_ex;
  logic [31:0] rs_ex;
  logic [31:0] rt_ex;
  logic        cancel;
  logic        busy;
  logic        stall_ex;
  logic [31:0] mf_data;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  ex_muldiv #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
    .clk(clk), .rst(rst), .special_ex(special_ex), .funct_ex(funct_ex),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .cancel(cancel), .busy(busy),
    .stall_ex(stall_ex), .mf_data(mf_data), .hi_o(hi_o), .lo_o(lo_o)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Model state: architectural HI/LO plus remaining busy cycles and pending result
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  int          m_left;
  logic        last_stall, last_exp_stall;
  logic [31:0] last_mf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void compute(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      6'h18: begin sp = sa * sb; {r_hi, r_lo} = sp; end
      6'h19: begin up = {32'b0, a} * {32'b0, b}; {r_hi, r_lo} = up; end
      6'h1a: begin
        if (b == 0) begin r_lo = 32'hffffffff; r_hi = a; end
        else if (a == 32'h80000000 && b == 32'hffffffff) begin r_lo = 32'h80000000; r_hi = 0; end
        else begin r_lo = 32'(sa / sb); r_hi = 32'(sa % sb); end
      end
      default: begin
        if (b == 0) begin r_lo = 32'hffffffff; r_hi = a; end
        else begin r_lo = a / b; r_hi = a % b; end
      end
    endcase
  endfunction

  function automatic void model_step(input logic sp, input logic [5:0] f,
                                     input logic [31:0] a, input logic [31:0] b, input logic c);
    if (m_left > 0) begin
      if (c) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin m_hi = r_hi; m_lo = r_lo; end
      end
    end else if (sp && f inside {[6'h18:6'h1b]} && !c) begin
      compute(f, a, b);
      m_left = (f <= 6'h19) ? 32 : 33;
    end else if (sp && f == 6'h11) m_hi = a;
    else if (sp && f == 6'h13) m_lo = a;
  endfunction

  function automatic void model_reset();
    m_hi = 0; m_lo = 0; m_left = 0;
  endfunction

  // One clock: drive, check combinational outputs, step model at the edge, check registers
  task automatic cyc(input logic sp, input logic [5:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic c);
    logic hl;
    logic exp_stall;
    logic [31:0] exp_mf;
    special_ex = sp; funct_ex = f; rs_ex = a; rt_ex = b; cancel = c;
    #1;
    hl = sp && (f inside {[6'h10:6'h13], [6'h18:6'h1b]});
    exp_stall = (m_left > 0) && hl;
    exp_mf = (sp && f == 6'h10) ? m_hi : ((sp && f == 6'h12) ? m_lo : 32'h0);
    chk("stall_ex", 32'(stall_ex), 32'(exp_stall));
    chk("mf_data", mf_data, exp_mf);
    last_stall = stall_ex; last_exp_stall = exp_stall; last_mf = mf_data;
    @(posedge clk);
    model_step(sp, f, a, b, c);
    #1;
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("hi_o", hi_o, m_hi);
    chk("lo_o", lo_o, m_lo);
  endtask

  task automatic idle();
    cyc(1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
  endtask

  // Issue an op, then idle until busy falls; n = busy cycles seen (bounded)
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int n);
    int guard;
    cyc(1'b1, f, a, b, 1'b0);
    n = busy ? 1 : 0;
    guard = 0;
    while (busy && guard < 40) begin
      idle();
      if (busy) n++;
      guard++;
    end
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic h_sp;
    logic [5:0] h_f;
    logic [31:0] h_a, h_b;
    logic [5:0] ops [8];
    ops = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b};
    rst = 1'b1; special_ex = 1'b0; funct_ex = 6'h0; rs_ex = 0; rt_ex = 0; cancel = 1'b0;
    model_reset();
    last_exp_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst hi", hi_o, 32'h0);
    chk("rst lo", lo_o, 32'h0);
    chk("rst stall", 32'(stall_ex), 32'h0);
    chk("rst mf", mf_data, 32'h0);
    rst = 1'b0;

    run_op(6'h18, 32'hffffffff, 32'h2, n);
    chk("mult busy len", 32'(n), 32'd32);
    chk("mult hi", hi_o, 32'hffffffff);
    chk("mult lo", lo_o, 32'hfffffffe);

    run_op(6'h19, 32'hffffffff, 32'h2, n);
    chk("multu hi", hi_o, 32'h1);
    chk("multu lo", lo_o, 32'hfffffffe);

    run_op(6'h1a, 32'hfffffff9, 32'h2, n);
    chk("div busy len", 32'(n), 32'd33);
    chk("div lo", lo_o, 32'hfffffffd);
    chk("div hi", hi_o, 32'hffffffff);

    run_op(6'h1b, 32'h7, 32'h0, n);
    chk("divu0 lo", lo_o, 32'hffffffff);
    chk("divu0 hi", hi_o, 32'h7);

    run_op(6'h1a, 32'h80000000, 32'hffffffff, n);
    chk("divovf lo", lo_o, 32'h80000000);
    chk("divovf hi", hi_o, 32'h0);

    // MFLO waiting behind a MULT
    cyc(1'b1, 6'h18, 32'h3, 32'h5, 1'b0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 6'h12, 32'h0, 32'h0, 1'b0);
      if (!last_stall) break;
      n++;
    end
    chk("mflo stall len", 32'(n), 32'd32);
    chk("mflo data", last_mf, 32'hf);

    // Unrelated instruction never stalls
    cyc(1'b1, 6'h18, 32'h3, 32'h5, 1'b0);
    cyc(1'b1, 6'h20, 32'h1, 32'h1, 1'b0);
    chk("add no stall", 32'(last_stall), 32'h0);
    run_op(6'h00, 32'h0, 32'h0, n);

    cyc(1'b1, 6'h13, 32'h1234, 32'h0, 1'b0);
    cyc(1'b1, 6'h12, 32'h0, 32'h0, 1'b0);
    chk("mtlo mflo data", last_mf, 32'h1234);
    chk("mtlo mflo stall", 32'(last_stall), 32'h0);

    // Cancel at t+5 discards a DIV
    cyc(1'b1, 6'h11, 32'haaaa, 32'h0, 1'b0);
    cyc(1'b1, 6'h13, 32'h5555, 32'h0, 1'b0);
    cyc(1'b1, 6'h1a, 32'h64, 32'h7, 1'b0);
    repeat (4) idle();
    cyc(1'b0, 6'h00, 32'h0, 32'h0, 1'b1);
    chk("cancel busy", 32'(busy), 32'h0);
    chk("cancel hi", hi_o, 32'haaaa);
    chk("cancel lo", lo_o, 32'h5555);

    // Cancel in IDLE does not block MTHI
    cyc(1'b1, 6'h11, 32'hbeef, 32'h0, 1'b1);
    chk("cancel idle mthi", hi_o, 32'hbeef);

    // Asynchronous reset in the middle of a MULT
    cyc(1'b1, 6'h18, 32'h1234567, 32'h89abcd, 1'b0);
    repeat (5) idle();
    #2 rst = 1'b1;
    #1;
    chk("arst busy", 32'(busy), 32'h0);
    chk("arst hi", hi_o, 32'h0);
    chk("arst lo", lo_o, 32'h0);
    model_reset();
    #1 rst = 1'b0;

    // Randomized traffic; stalled instructions are held until they issue
    h_sp = 1'b0; h_f = 6'h0; h_a = 0; h_b = 0;
    for (int i = 0; i < 2500; i++) begin
      if (!last_exp_stall) begin
        n = $urandom_range(0, 99);
        h_a = pick_op();
        h_b = pick_op();
        if (n < 35)      begin h_sp = 1'b1; h_f = ops[$urandom_range(4, 7)]; end
        else if (n < 65) begin h_sp = 1'b1; h_f = ops[$urandom_range(0, 3)]; end
        else if (n < 80) begin h_sp = 1'b1; h_f = 6'h20; end
        else             begin h_sp = 1'b0; h_f = ops[$urandom_range(0, 7)]; end
      end
      cyc(h_sp, h_f, h_a, h_b, ($urandom_range(0, 59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
